// File: rtl/logic_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : logic_arb                                                 |
// | Description : Two-requester round-robin arbiter in front of a bitwise   |
// |               AND/OR/XOR unit with a valid/ready result port.           |
// |               Define LOGIC_ARB_XOR_EN to enable opcode 2'b10 (XOR).     |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module logic_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic [15:0]      op_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CALC   = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
`ifdef LOGIC_ARB_XOR_EN
    localparam logic [1:0] c_OP_XOR = 2'b10;
`endif

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]       r_state;
    logic             r_last_gnt;
    logic             r_gnt_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;
    logic             r_res_err;
    logic [15:0]      r_op_cnt;

    logic             w_any_req;
    logic             w_gnt;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_err;

    // Single requester wins outright; with both pending, the one not served last wins.
    assign w_any_req  = req0_valid | req1_valid;
    assign w_gnt      = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;
    // Qualified by rst so the ready outputs stay low throughout reset.
    assign w_accept   = rst & (r_state == c_IDLE) & w_any_req;

    assign req0_ready = w_accept & ~w_gnt;
    assign req1_ready = w_accept &  w_gnt;

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
`ifdef LOGIC_ARB_XOR_EN
            c_OP_XOR: w_result = r_a ^ r_b;
`endif
            default:  w_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt_id   <= 1'b0;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_res_data <= '0;
            r_res_id   <= 1'b0;
            r_res_err  <= 1'b0;
            r_op_cnt   <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_gnt ? req1_op : req0_op;
                        r_a        <= w_gnt ? req1_a  : req0_a;
                        r_b        <= w_gnt ? req1_b  : req0_b;
                        r_gnt_id   <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_state    <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_res_data <= w_result;
                    r_res_err  <= w_err;
                    r_res_id   <= r_gnt_id;
                    r_state    <= c_DONE;
                end
                c_DONE: begin
                    // Result fields are held until the consumer takes them.
                    if (res_ready) begin
                        r_state <= c_IDLE;
                        if (r_op_cnt != c_CNT_MAX) begin
                            r_op_cnt <= r_op_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == c_DONE);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign res_err   = r_res_err;
    assign op_cnt    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_logic_arb                                              |
// | Description : Self-checking bench for logic_arb against a transaction-  |
// |               level reference model; honours LOGIC_ARB_XOR_EN.          |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_logic_arb;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id, res_err;
    logic [15:0]      op_cnt;

    always #5 clk = ~clk;

    logic_arb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_err(res_err), .op_cnt(op_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one operation in flight, result visible two cycles after accept.
    bit         m_busy;
    int         m_age;
    bit         m_last;
    logic [7:0] m_data;
    bit         m_id;
    bit         m_err;
    int         m_cnt;

    logic       gq[$];
    logic [9:0] rq[$];

    function automatic logic [8:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0: return {1'b0, a & b};
            2'd1: return {1'b0, a | b};
`ifdef LOGIC_ARB_XOR_EN
            2'd2: return {1'b0, a ^ b};
`endif
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_last = 1; m_cnt = 0;
    endtask

    task automatic step(input logic v0, input logic [1:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [1:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic rr);
        bit         g, acc, rv;
        logic [8:0] r;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #2;
        acc = !m_busy && (v0 || v1);
        g   = (v0 && v1) ? !m_last : v1;
        rv  = m_busy && (m_age == 2);
        chk("req0_ready", req0_ready, acc && !g);
        chk("req1_ready", req1_ready, acc && g);
        chk("res_valid", res_valid, rv);
        chk("op_cnt", op_cnt, m_cnt);
        if (rv) begin
            chk("res_data", res_data, m_data);
            chk("res_id", res_id, m_id);
            chk("res_err", res_err, m_err);
        end
        if (req0_ready || req1_ready) gq.push_back(req1_ready);
        if (rv && rr) rq.push_back({res_err, res_id, res_data});
        if (rv && rr) begin
            m_busy = 0;
            if (m_cnt != 16'hFFFF) m_cnt++;
        end else if (m_busy && m_age < 2) begin
            m_age++;
        end else if (acc) begin
            r      = g ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
            m_busy = 1; m_age = 1;
            m_data = r[7:0]; m_err = r[8]; m_id = g; m_last = g;
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rr);
        step(0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, rr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_data"}, res_data, 0);
        chk({tag, "_id"}, res_id, 0);
        chk({tag, "_err"}, res_err, 0);
        chk({tag, "_cnt"}, op_cnt, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 0; req0_valid = 1; req1_valid = 1; res_ready = 1;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 1;
        model_reset();
    endtask

    logic [7:0] bp_first;

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; res_ready = 0;
        #3 rst = 0;
        model_reset();
        apply_reset();

        // Single AND request with res_ready held high
        rq.delete();
        step(1, 2'd0, 8'h18, 8'hE7, 0, 2'd0, 8'h00, 8'h00, 1);
        idle(1); idle(1); idle(1);
        #1;
        chk("single_nres", rq.size(), 1);
        if (rq.size() > 0) begin
            chk("single_data", rq[0][7:0], 8'h00);
            chk("single_id", rq[0][8], 0);
            chk("single_err", rq[0][9], 0);
        end
        chk("single_cnt", op_cnt, 1);

        // Contention from a fresh reset
        apply_reset();
        gq.delete(); rq.delete();
        for (int i = 0; i < 12; i++) step(1, 2'd1, 8'h18, 8'hE7, 1, 2'd0, 8'hFF, 8'h0F, 1);
        chk("cont_ngrants", gq.size() >= 4, 1);
        chk("cont_nres", rq.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("cont_grant", gq[i], i % 2);
            if (i < rq.size()) chk("cont_data", rq[i][7:0], (i % 2) ? 8'h0F : 8'hFF);
        end

        // Backpressure: five DONE cycles with res_ready low and both requesters waiting
        gq.delete();
        idle(1); idle(1); idle(1);
        step(1, 2'd1, 8'h30, 8'h05, 0, 2'd0, 8'h00, 8'h00, 0);
        idle(0);
        #1 bp_first = res_data;
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd0, 8'hAA, 8'h55, 1, 2'd1, 8'h11, 8'h22, 0);
            chk("bp_stable", res_data, bp_first);
        end
        chk("bp_nacc", gq.size(), 1);
        step(1, 2'd0, 8'hAA, 8'h55, 1, 2'd1, 8'h11, 8'h22, 1);
        chk("bp_nacc_hs", gq.size(), 1);
        step(1, 2'd0, 8'hAA, 8'h55, 1, 2'd1, 8'h11, 8'h22, 1);
        chk("bp_acc_after", gq.size(), 2);
        idle(1); idle(1); idle(1);

        // Opcodes 10 and 11 from requester 1
        rq.delete();
        step(0, 2'd0, 8'h00, 8'h00, 1, 2'd2, 8'h18, 8'hE7, 1);
        idle(1); idle(1);
        step(0, 2'd0, 8'h00, 8'h00, 1, 2'd3, 8'h18, 8'hE7, 1);
        idle(1); idle(1); idle(1);
        chk("op_nres", rq.size(), 2);
        if (rq.size() >= 2) begin
`ifdef LOGIC_ARB_XOR_EN
            chk("op10_data", rq[0][7:0], 8'hFF);
            chk("op10_err", rq[0][9], 0);
`else
            chk("op10_data", rq[0][7:0], 8'h00);
            chk("op10_err", rq[0][9], 1);
`endif
            chk("op10_id", rq[0][8], 1);
            chk("op11_data", rq[1][7:0], 8'h00);
            chk("op11_err", rq[1][9], 1);
        end

        // Reset pulsed during CALC after a req0 accept
        apply_reset();
        step(1, 2'd1, 8'h0F, 8'hF0, 0, 2'd0, 8'h00, 8'h00, 1);
        #2 rst = 0; req0_valid = 1; req1_valid = 1;
        #1 check_reset_outputs("midcalc");
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 1;
        model_reset();
        gq.delete();
        step(1, 2'd0, 8'h3C, 8'h0F, 1, 2'd1, 8'h01, 8'h02, 1);
        chk("midcalc_ngrant", gq.size(), 1);
        if (gq.size() > 0) chk("midcalc_grant", gq[0], 0);
        idle(1); idle(1); idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
